// File: rtl/time_set_controller.sv
// time_set_controller: button-driven editor for the clock's time and alarm.
// Fields are edited in 12-hour form (hour, minute, am/pm). The result is then
// committed either as a one-cycle set_time load or into the held alarm registers.
module time_set_controller #(
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic       clock_sec,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_cancel,
    input  logic       target_alarm,
    input  logic [3:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic       cur_am_pm,
    output logic       set_time,
    output logic [3:0] set_hour,
    output logic [5:0] set_minute,
    output logic       set_am_pm,
    output logic [3:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       alarm_am_pm,
    output logic       edit_active,
    output logic [1:0] edit_field
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, EDIT_HOUR, EDIT_MIN, EDIT_AMPM, COMMIT} state_t;

    state_t         state, state_nxt;
    logic           mode_prev, inc_prev, dec_prev, cancel_prev;
    logic           mode_e, inc_e, dec_e, cancel_e, any_e, adj;
    logic [3:0]     wh, ld_hour;
    logic [5:0]     wm, ld_minute;
    logic           wap, ld_am_pm, target;
    logic [CW-1:0]  tcnt;
    logic           tmo;

    assign mode_e   = btn_mode   & ~mode_prev;
    assign inc_e    = btn_inc    & ~inc_prev;
    assign dec_e    = btn_dec    & ~dec_prev;
    assign cancel_e = btn_cancel & ~cancel_prev;
    assign any_e    = mode_e | inc_e | dec_e | cancel_e;
    // A field is adjusted only when exactly one of inc/dec fired and nothing
    // with higher priority (cancel, mode) did.
    assign adj      = ~cancel_e & ~mode_e & (inc_e ^ dec_e);
    assign tmo      = ~any_e & (tcnt == CW'(TIMEOUT_CYCLES - 1));

    // Source for the working registers while idle, with illegal values forced legal
    assign ld_hour   = target_alarm ? alarm_hour   : cur_hour;
    assign ld_minute = target_alarm ? alarm_minute : cur_minute;
    assign ld_am_pm  = target_alarm ? alarm_am_pm  : cur_am_pm;

    // Button history; resets high so a button held through reset must be re-pressed
    always_ff @(posedge clock_sec or negedge reset_n) begin
        if (!reset_n) begin
            mode_prev   <= 1'b1;
            inc_prev    <= 1'b1;
            dec_prev    <= 1'b1;
            cancel_prev <= 1'b1;
        end else begin
            mode_prev   <= btn_mode;
            inc_prev    <= btn_inc;
            dec_prev    <= btn_dec;
            cancel_prev <= btn_cancel;
        end
    end

    // State register
    always_ff @(posedge clock_sec or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: cancel beats mode, inactivity timeout abandons the edit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (mode_e) state_nxt = EDIT_HOUR;
            EDIT_HOUR: if (cancel_e || tmo) state_nxt = IDLE;
                       else if (mode_e)     state_nxt = EDIT_MIN;
            EDIT_MIN:  if (cancel_e || tmo) state_nxt = IDLE;
                       else if (mode_e)     state_nxt = EDIT_AMPM;
            EDIT_AMPM: if (cancel_e || tmo) state_nxt = IDLE;
                       else if (mode_e)     state_nxt = COMMIT;
            COMMIT:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        edit_active = (state != IDLE);
        set_time    = (state == COMMIT) & ~target;
        case (state)
            EDIT_HOUR: edit_field = 2'd1;
            EDIT_MIN:  edit_field = 2'd2;
            EDIT_AMPM: edit_field = 2'd3;
            default:   edit_field = 2'd0;
        endcase
    end

    // Working registers, target latch and inactivity counter
    always_ff @(posedge clock_sec or negedge reset_n) begin
        if (!reset_n) begin
            wh     <= 4'd12;
            wm     <= 6'd0;
            wap    <= 1'b0;
            target <= 1'b0;
            tcnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    target <= target_alarm;
                    wh     <= (ld_hour == 4'd0 || ld_hour > 4'd12) ? 4'd12 : ld_hour;
                    wm     <= (ld_minute > 6'd59) ? 6'd0 : ld_minute;
                    wap    <= ld_am_pm;
                    tcnt   <= '0;
                end
                EDIT_HOUR, EDIT_MIN, EDIT_AMPM: begin
                    if (any_e)     tcnt <= '0;
                    else if (!tmo) tcnt <= tcnt + CW'(1);
                    if (adj) begin
                        case (state)
                            EDIT_HOUR: if (inc_e) wh <= (wh == 4'd12) ? 4'd1  : wh + 4'd1;
                                       else       wh <= (wh == 4'd1)  ? 4'd12 : wh - 4'd1;
                            EDIT_MIN:  if (inc_e) wm <= (wm == 6'd59) ? 6'd0  : wm + 6'd1;
                                       else       wm <= (wm == 6'd0)  ? 6'd59 : wm - 6'd1;
                            default:   wap <= ~wap;
                        endcase
                    end
                end
                default: tcnt <= '0;
            endcase
        end
    end

    // Committed values load on the edge into COMMIT so they are valid alongside set_time
    always_ff @(posedge clock_sec or negedge reset_n) begin
        if (!reset_n) begin
            set_hour     <= 4'd12;
            set_minute   <= 6'd0;
            set_am_pm    <= 1'b0;
            alarm_hour   <= 4'd12;
            alarm_minute <= 6'd0;
            alarm_am_pm  <= 1'b0;
        end else if (state == EDIT_AMPM && state_nxt == COMMIT) begin
            if (!target) begin
                set_hour   <= wh;
                set_minute <= wm;
                set_am_pm  <= wap;
            end else begin
                alarm_hour   <= wh;
                alarm_minute <= wm;
                alarm_am_pm  <= wap;
            end
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed edit sessions. Each session's expected
// outcome is queued when stimulus starts; a negedge monitor pops and compares
// when the DUT leaves editing.
module tb_time_set_controller;

    logic       clock_sec = 1'b0;
    logic       reset_n   = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
    logic       target_alarm = 1'b0;
    logic [3:0] cur_hour = 4'd2;
    logic [5:0] cur_minute = 6'd45;
    logic       cur_am_pm = 1'b1;
    logic       set_time, set_am_pm, alarm_am_pm, edit_active;
    logic [3:0] set_hour, alarm_hour;
    logic [5:0] set_minute, alarm_minute;
    logic [1:0] edit_field;

    time_set_controller #(.TIMEOUT_CYCLES(30)) dut (
        .clock_sec(clock_sec), .reset_n(reset_n),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
        .target_alarm(target_alarm),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_am_pm(cur_am_pm),
        .set_time(set_time), .set_hour(set_hour), .set_minute(set_minute), .set_am_pm(set_am_pm),
        .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_am_pm(alarm_am_pm),
        .edit_active(edit_active), .edit_field(edit_field)
    );

    always #5 clock_sec = ~clock_sec;

    typedef struct {
        int commit, pulses, sh, sm, sap, ah, am, aap;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   s_pulses = 0, s_commit = 0, idle_st = 0, sessions = 0;
    logic prev_act = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_sec);
        #1;
    endtask

    // m bits: 0 mode, 1 inc, 2 dec, 3 cancel; held one cycle then released one cycle
    task automatic press(input int m);
        logic [3:0] b;
        b = m[3:0];
        {btn_cancel, btn_dec, btn_inc, btn_mode} = b;
        tick();
        {btn_cancel, btn_dec, btn_inc, btn_mode} = 4'b0;
        tick();
    endtask

    task automatic expect_session(input int c, input int p, input int sh, input int sm,
                                  input int sap, input int ah, input int am, input int aap);
        exp_t e;
        e.commit = c; e.pulses = p; e.sh = sh; e.sm = sm; e.sap = sap;
        e.ah = ah; e.am = am; e.aap = aap;
        q.push_back(e);
    endtask

    // Monitor: track each editing session and score it when editing ends
    always @(negedge clock_sec) begin
        exp_t e;
        if (edit_active === 1'b1) begin
            if (!prev_act) begin
                s_pulses = 0;
                s_commit = 0;
            end
            if (set_time === 1'b1) s_pulses++;
            if (edit_field == 2'd0) s_commit = 1;
        end else begin
            if (set_time === 1'b1) idle_st++;
            if (prev_act) begin
                sessions++;
                if (q.size() == 0) chk("unexpected_session", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("commit_seen",  s_commit,     e.commit);
                    chk("set_time_pulses", s_pulses,  e.pulses);
                    chk("set_hour",     set_hour,     e.sh);
                    chk("set_minute",   set_minute,   e.sm);
                    chk("set_am_pm",    set_am_pm,    e.sap);
                    chk("alarm_hour",   alarm_hour,   e.ah);
                    chk("alarm_minute", alarm_minute, e.am);
                    chk("alarm_am_pm",  alarm_am_pm,  e.aap);
                end
            end
        end
        prev_act = (edit_active === 1'b1);
    end

    initial begin
        // Reset with mode held: no edit until released and pressed again
        btn_mode = 1'b1;
        repeat (3) tick();
        chk("rst_set_hour", set_hour, 12);
        chk("rst_set_minute", set_minute, 0);
        chk("rst_set_am_pm", set_am_pm, 0);
        chk("rst_alarm_hour", alarm_hour, 12);
        chk("rst_alarm_minute", alarm_minute, 0);
        chk("rst_alarm_am_pm", alarm_am_pm, 0);
        chk("rst_edit_active", edit_active, 0);
        chk("rst_edit_field", edit_field, 0);
        chk("rst_set_time", set_time, 0);
        reset_n = 1'b1;
        repeat (4) tick();
        chk("held_mode_no_edit", edit_active, 0);
        btn_mode = 1'b0;
        tick();
        expect_session(0, 0, 12, 0, 0, 12, 0, 0);
        press(1);
        chk("repress_active", edit_active, 1);
        chk("repress_field", edit_field, 1);
        press(8);

        // Set time from 2:45 pm -> 5:59 am
        target_alarm = 1'b0; cur_hour = 4'd2; cur_minute = 6'd45; cur_am_pm = 1'b1;
        expect_session(1, 1, 5, 59, 0, 12, 0, 0);
        press(1);
        cur_hour = 4'd9; cur_minute = 6'd9;
        chk("field_hour", edit_field, 1);
        repeat (3) press(2);
        press(1);
        chk("field_min", edit_field, 2);
        repeat (46) press(4);
        press(1);
        chk("field_ampm", edit_field, 3);
        press(2);
        press(1);
        repeat (3) tick();
        chk("hold_set_hour", set_hour, 5);
        chk("hold_set_minute", set_minute, 59);
        chk("hold_set_time_low", set_time, 0);

        // Set alarm from reset value -> 11:01 am
        target_alarm = 1'b1;
        expect_session(1, 0, 5, 59, 0, 11, 1, 0);
        press(1);
        target_alarm = 1'b0;
        press(4); press(1); press(2); press(1); press(1);

        // Wrap boundaries on the alarm: 11:01 am -> 10:02 pm
        target_alarm = 1'b1;
        expect_session(1, 0, 5, 59, 0, 10, 2, 1);
        press(1);
        press(2); press(2); press(6); press(4); press(4); press(4);
        press(1);
        press(4); press(4); press(2); press(6); press(2); press(2);
        press(1);
        press(2); press(6);
        press(1);

        // Cancel in EDIT_MIN
        target_alarm = 1'b0; cur_hour = 4'd7; cur_minute = 6'd30; cur_am_pm = 1'b0;
        expect_session(0, 0, 5, 59, 0, 10, 2, 1);
        press(1); press(2); press(1); press(2);
        btn_cancel = 1'b1;
        tick();
        chk("cancel_idle", edit_active, 0);
        chk("cancel_field", edit_field, 0);
        btn_cancel = 1'b0;
        tick();

        // inc/dec/cancel in IDLE are ignored
        press(2); press(4); press(8);
        chk("idle_ignore", edit_active, 0);

        // Timeout after 30 idle cycles in EDIT_HOUR
        expect_session(0, 0, 5, 59, 0, 10, 2, 1);
        press(1);
        repeat (28) tick();
        chk("tmo_not_yet", edit_active, 1);
        tick();
        chk("tmo_expired", edit_active, 0);

        // An inc edge in cycle 29 restarts the count
        expect_session(0, 0, 5, 59, 0, 10, 2, 1);
        press(1);
        repeat (27) tick();
        btn_inc = 1'b1;
        tick();
        chk("tmo_restart_alive", edit_active, 1);
        btn_inc = 1'b0;
        repeat (29) tick();
        chk("tmo_restart_not_yet", edit_active, 1);
        tick();
        chk("tmo_restart_expired", edit_active, 0);

        // Illegal load values are sanitised
        cur_hour = 4'd0; cur_minute = 6'd63; cur_am_pm = 1'b1;
        expect_session(1, 1, 12, 0, 1, 10, 2, 1);
        repeat (4) press(1);

        // mode beats inc
        cur_hour = 4'd3; cur_minute = 6'd10; cur_am_pm = 1'b0;
        expect_session(1, 1, 3, 10, 0, 10, 2, 1);
        press(1);
        press(3);
        chk("mode_inc_field", edit_field, 2);
        press(1); press(1);

        // cancel beats mode
        expect_session(0, 0, 3, 10, 0, 10, 2, 1);
        press(1);
        btn_mode = 1'b1; btn_cancel = 1'b1;
        tick();
        chk("cancel_mode_idle", edit_active, 0);
        btn_mode = 1'b0; btn_cancel = 1'b0;
        tick();

        // Reset mid-edit returns everything to reset values
        cur_hour = 4'd4; cur_minute = 6'd20;
        expect_session(0, 0, 12, 0, 0, 12, 0, 0);
        press(1); press(2); press(1);
        reset_n = 1'b0;
        #2;
        chk("midrst_active", edit_active, 0);
        chk("midrst_set_hour", set_hour, 12);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("queue_drained", q.size(), 0);
        chk("sessions", sessions, 11);
        chk("idle_set_time", idle_st, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
